result_display_driver: RTL and testbench



---
 rtl/result_display_driver.sv | 183 ++++++++++++++++++
 tb/tb_result_display_driver.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/result_display_driver.sv
// result_display_driver
//   Captures a 16-bit result word and its overflow flag, converts it to a sign
//   and five BCD digits with an iterative double-dabble sequencer, and drives a
//   six-digit multiplexed common-anode 7-segment display.
//
// Ports:
//   Clock    in   system clock, rising edge
//   Clear    in   asynchronous active-low reset
//   Load     in   capture request (honoured only in IDLE)
//   Value    in   [15:0] result word to convert
//   Signed   in   1 = Value is two's complement
//   OVR      in   overflow flag accompanying Value
//   Busy     out  conversion in progress
//   Done     out  one-cycle pulse when Digits/Negative are updated
//   Digits   out  [19:0] BCD magnitude, [19:16] = digit4 .. [3:0] = digit0
//   Negative out  sign of the last converted value
//   Seg      out  [6:0] segments gfedcba, active-low
//   An       out  [5:0] digit enables, active-low one-hot, bit5 = sign digit
module result_display_driver #(
  parameter int unsigned REFRESH_DIV   = 50000,
  parameter bit          BLANK_LEADING = 1'b1
) (
  input  logic        Clock,
  input  logic        Clear,
  input  logic        Load,
  input  logic [15:0] Value,
  input  logic        Signed,
  input  logic        OVR,
  output logic        Busy,
  output logic        Done,
  output logic [19:0] Digits,
  output logic        Negative,
  output logic [6:0]  Seg,
  output logic [5:0]  An
);

  localparam int unsigned PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;

  typedef enum logic [1:0] {IDLE, ABS, SHIFT, LATCH} state_t;

  state_t      state;
  logic [15:0] val_q;
  logic        sgn_q;
  logic        ovr_q;
  logic [15:0] mag;
  logic [19:0] bcd;
  logic [19:0] bcd_adj;
  logic [3:0]  bit_cnt;
  logic        err;

  logic [PW-1:0] presc;
  logic [2:0]    scan_idx;

  // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
  always_comb begin
    bcd_adj = bcd;
    for (int unsigned i = 0; i < 5; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5)
        bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
    end
  end

  // Conversion sequencer. Digits/Negative are only written in LATCH, so the
  // display keeps showing the previous value while a conversion runs.
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state    <= IDLE;
      val_q    <= '0;
      sgn_q    <= 1'b0;
      ovr_q    <= 1'b0;
      mag      <= '0;
      bcd      <= '0;
      bit_cnt  <= '0;
      err      <= 1'b0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      Digits   <= '0;
      Negative <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Load) begin
            val_q <= Value;
            sgn_q <= Signed;
            ovr_q <= OVR;
            Busy  <= 1'b1;
            state <= ABS;
          end
        end
        ABS: begin
          // 16'h8000 signed negates to itself, which read unsigned is 32768.
          mag     <= (sgn_q & val_q[15]) ? -val_q : val_q;
          bcd     <= '0;
          bit_cnt <= '0;
          state   <= SHIFT;
        end
        SHIFT: begin
          {bcd, mag} <= {bcd_adj[18:0], mag, 1'b0};
          bit_cnt    <= bit_cnt + 4'd1;
          if (bit_cnt == 4'd15)
            state <= LATCH;
        end
        LATCH: begin
          if (ovr_q) begin
            Digits   <= '0;
            Negative <= 1'b0;
            err      <= 1'b1;
          end else begin
            Digits   <= bcd;
            Negative <= sgn_q & val_q[15];
            err      <= 1'b0;
          end
          Busy  <= 1'b0;
          Done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Scan prescaler and digit index.
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      presc    <= '0;
      scan_idx <= '0;
    end else if (presc == PW'(REFRESH_DIV - 1)) begin
      presc    <= '0;
      scan_idx <= (scan_idx == 3'd5) ? 3'd0 : scan_idx + 3'd1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  // shown[i]: digit i is at or below the most significant nonzero digit.
  logic [4:0] shown;
  always_comb begin
    shown    = '1;
    shown[4] = (Digits[19:16] != 4'd0);
    shown[3] = shown[4] | (Digits[15:12] != 4'd0);
    shown[2] = shown[3] | (Digits[11:8]  != 4'd0);
    shown[1] = shown[2] | (Digits[7:4]   != 4'd0);
    shown[0] = 1'b1;
    if (!BLANK_LEADING)
      shown = '1;
  end

  always_comb begin
    An  = ~(6'b000001 << scan_idx);
    Seg = SEG_BLANK;
    case (scan_idx)
      3'd0: Seg = err ? SEG_E : seg7(Digits[3:0]);
      3'd1: Seg = (!err && shown[1]) ? seg7(Digits[7:4])   : SEG_BLANK;
      3'd2: Seg = (!err && shown[2]) ? seg7(Digits[11:8])  : SEG_BLANK;
      3'd3: Seg = (!err && shown[3]) ? seg7(Digits[15:12]) : SEG_BLANK;
      3'd4: Seg = (!err && shown[4]) ? seg7(Digits[19:16]) : SEG_BLANK;
      3'd5: Seg = (!err && Negative) ? SEG_MINUS : SEG_BLANK;
      default: Seg = SEG_BLANK;
    endcase
  end

endmodule

// File: tb/tb_result_display_driver.sv
// tb_result_display_driver
//   Scoreboard bench for result_display_driver: each Load pushes the expected
//   Digits/Negative into a queue; a monitor pops and compares on every Done.
//   Display contents are checked per digit with hand-computed segment codes.
module tb_result_display_driver;

  logic        Clock = 1'b0;
  logic        Clear = 1'b0;
  logic        Load = 1'b0;
  logic [15:0] Value = '0;
  logic        Signed = 1'b0;
  logic        OVR = 1'b0;
  logic        Busy;
  logic        Done;
  logic [19:0] Digits;
  logic        Negative;
  logic [6:0]  Seg;
  logic [5:0]  An;

  localparam logic [6:0] SG0 = 7'b1000000, SG1 = 7'b1111001, SG2 = 7'b0100100,
                         SG3 = 7'b0110000, SG4 = 7'b0011001, SG5 = 7'b0010010,
                         SG6 = 7'b0000010, SG7 = 7'b1111000, SG8 = 7'b0000000,
                         SBL = 7'b1111111, SMN = 7'b0111111, SE  = 7'b0000110;

  result_display_driver #(.REFRESH_DIV(4), .BLANK_LEADING(1'b1)) dut (
    .Clock(Clock), .Clear(Clear), .Load(Load), .Value(Value), .Signed(Signed),
    .OVR(OVR), .Busy(Busy), .Done(Done), .Digits(Digits), .Negative(Negative),
    .Seg(Seg), .An(An)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [19:0] d;
    logic        n;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Monitor: every Done must match the oldest outstanding expectation.
  always @(negedge Clock) begin
    exp_t e;
    if (Done === 1'b1) begin
      done_cnt++;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 required=0");
      end else begin
        e = q.pop_front();
        chk("digits", 32'(Digits), 32'(e.d));
        chk("negative", 32'(Negative), 32'(e.n));
      end
    end
  end

  // Issue one Load; optionally pulse Load again at busy cycles 5 and 9.
  task automatic run_load(input logic [15:0] v, input logic s, input logic o,
                          input logic [19:0] ed, input logic en, input bit poke);
    int n;
    bit seen;
    q.push_back({ed, en});
    @(posedge Clock); #1;
    Value = v; Signed = s; OVR = o; Load = 1'b1;
    @(posedge Clock); #1;
    Load = 1'b0;
    chk("busy_rise", 32'(Busy), 32'd1);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(posedge Clock);
      n++;
      #1;
      Load = (poke && (n == 5 || n == 9)) ? 1'b1 : 1'b0;
      if (Done) seen = 1'b1;
    end
    Load = 1'b0;
    chk("latency", 32'(n), 32'd18);
    chk("busy_fall", 32'(Busy), 32'd0);
  endtask

  // exp = {sign, d4, d3, d2, d1, d0}, 7 bits each.
  task automatic check_disp(input string nm, input logic [41:0] exp);
    for (int i = 0; i < 6; i++) begin
      int w;
      logic [5:0] an_exp;
      an_exp = ~(6'b000001 << i);
      w = 0;
      @(negedge Clock);
      while (An !== an_exp && w < 40) begin
        @(negedge Clock);
        w++;
      end
      if (w >= 40) chk({nm, "_an_timeout"}, 32'(An), 32'(an_exp));
      else         chk($sformatf("%s_seg%0d", nm, i), 32'(Seg), 32'(exp[i*7 +: 7]));
    end
  endtask

  initial begin
    int dc0;
    #23 Clear = 1'b1;
    repeat (10) @(posedge Clock);
    #1 Clear = 1'b0;
    #1;
    chk("rst_an", 32'(An), 32'(6'b111110));
    chk("rst_seg", 32'(Seg), 32'(SG0));
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_digits", 32'(Digits), 32'd0);
    chk("rst_neg", 32'(Negative), 32'd0);
    #2 Clear = 1'b1;
    repeat (3) @(posedge Clock);
    #1 chk("walk_hold", 32'(An), 32'(6'b111110));
    @(posedge Clock);
    #1 chk("walk_1", 32'(An), 32'(6'b111101));
    repeat (4) @(posedge Clock);
    #1 chk("walk_2", 32'(An), 32'(6'b111011));

    run_load(16'h04D2, 1'b1, 1'b0, 20'h01234, 1'b0, 1'b0);
    check_disp("d1234", {SBL, SBL, SG1, SG2, SG3, SG4});
    run_load(16'hFF85, 1'b1, 1'b0, 20'h00123, 1'b1, 1'b0);
    check_disp("dm123", {SMN, SBL, SBL, SG1, SG2, SG3});
    run_load(16'hFF85, 1'b0, 1'b0, 20'h65413, 1'b0, 1'b0);
    check_disp("d65413", {SBL, SG6, SG5, SG4, SG1, SG3});
    run_load(16'h8000, 1'b1, 1'b0, 20'h32768, 1'b1, 1'b0);
    check_disp("dm32768", {SMN, SG3, SG2, SG7, SG6, SG8});
    run_load(16'hFFFF, 1'b0, 1'b0, 20'h65535, 1'b0, 1'b0);
    run_load(16'h0000, 1'b1, 1'b0, 20'h00000, 1'b0, 1'b0);
    check_disp("d0", {SBL, SBL, SBL, SBL, SBL, SG0});
    run_load(16'h0005, 1'b0, 1'b1, 20'h00000, 1'b0, 1'b0);
    check_disp("derr", {SBL, SBL, SBL, SBL, SBL, SE});
    run_load(16'h0007, 1'b0, 1'b0, 20'h00007, 1'b0, 1'b0);
    check_disp("d7", {SBL, SBL, SBL, SBL, SBL, SG7});

    dc0 = done_cnt;
    run_load(16'h04D2, 1'b1, 1'b0, 20'h01234, 1'b0, 1'b1);
    repeat (30) @(posedge Clock);
    #1 chk("single_done", 32'(done_cnt - dc0), 32'd1);

    // Abort: Clear low during SHIFT cycle 8.
    dc0 = done_cnt;
    @(posedge Clock); #1;
    Value = 16'h1234; Signed = 1'b0; OVR = 1'b0; Load = 1'b1;
    @(posedge Clock); #1;
    Load = 1'b0;
    repeat (9) @(posedge Clock);
    #1 Clear = 1'b0;
    #1;
    chk("abort_busy", 32'(Busy), 32'd0);
    chk("abort_digits", 32'(Digits), 32'd0);
    chk("abort_an", 32'(An), 32'(6'b111110));
    repeat (25) @(posedge Clock);
    #1 chk("abort_no_done", 32'(done_cnt - dc0), 32'd0);
    #2 Clear = 1'b1;
    run_load(16'h0929, 1'b0, 1'b0, 20'h02345, 1'b0, 1'b0);
    check_disp("d2345", {SBL, SBL, SG2, SG3, SG4, SG5});

    repeat (5) @(posedge Clock);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
